gpio_int_arbiter: RTL and testbench
===================================

// Module: gpio_int_arbiter
// PURPOSE
//  Interrupt sequencer for the 16-bit GPIO port. Synchronises the port inputs and
//  edge-detects them per bit, using rising or falling polarity. Latches masked
//  events into pending bits and presents one vector at a time to the CPU with a
//  valid/ack handshake, using round-robin arbitration.
//  Sits between the GPIO register block (mask/edge/clear) and the CPU interrupt line.
// PARAMETERS
//  WIDTH        16  number of GPIO lines
//  SYNC_STAGES  2   input synchroniser depth (>=2)
//  FILT_CYCLES  4   stable-cycle count for glitch filter (used only with GPIO_INT_FILTER_EN)
// PORTS
//  Clk        in   1                  single clock; all state on posedge Clk
//  ResetN     in   1                  asynchronous, active-low reset
//  PortIn     in   WIDTH              raw port pin levels
//  IntMask    in   WIDTH              1 = line enabled
//  IntEdge    in   WIDTH              0 = rising edge, 1 = falling edge
//  IntClr     in   WIDTH              one-cycle write-one-to-clear of pending bits
//  IntAck     in   1                  CPU accepts presented vector
//  Pending    out  WIDTH              latched pending events
//  IntStatus  out  1                  registered OR of Pending
//  IntValid   out  1                  IntVec is valid
//  IntVec     out  $clog2(WIDTH)      index of presented line
// BEHAVIOUR
//  Reset (ResetN=0, async): Pending=0, IntStatus=0, IntValid=0, IntVec=0, rr pointer=0.
//   Synchroniser and previous-sample regs = 0. FSM = IDLE. Mid-handshake reset drops IntValid at once.
//  Edge detect: s = synchronised pin; p = s delayed one cycle.
//   hit = IntEdge ? (p & ~s) : (s & ~p).
//   First sample after reset: a pin held high at reset produces a rising hit.
//  Pending update, per bit, each cycle:
//   Pending <= (Pending & ~IntClr & ~AckClr | hit) & IntMask.
//   AckClr is the one-hot of IntVec when the handshake completes.
//   A new hit on the same cycle as its clear/ack wins: the bit stays set.
//   Deasserting a mask bit clears that pending bit on the next cycle.
//  Latency: pin edge -> Pending set after SYNC_STAGES+1 Clk.
//   Pending -> IntValid after 1 further Clk. IntStatus lags Pending by 1 Clk.
//  FSM:
//   IDLE: if |Pending, select the first set bit at or above ptr, wrapping WIDTH-1 -> 0.
//    IntVec <= idx, IntValid <= 1, go to PRESENT.
//   PRESENT: IntVec and IntValid are held stable.
//    IntAck=1: clear Pending[IntVec], ptr <= (IntVec+1) mod WIDTH, IntValid <= 0, go to IDLE.
//    Else if Pending[IntVec]=0 (cleared via IntClr or mask): withdraw.
//     IntValid <= 0, go to IDLE, ptr unchanged.
//   IDLE always lasts >= 1 cycle between vectors, so IntValid has a 1-cycle gap.
//   IntAck while IntValid=0 is ignored.
//  Fairness: a continuously pending line waits at most WIDTH-1 other grants.
// CONFIGURATION
//  `GPIO_INT_FILTER_EN defined:
//   Per-bit glitch filter after the synchroniser. s updates only after the synchronised
//   input differs from s for FILT_CYCLES consecutive Clk; the counter restarts on any bounce.
//   Latency becomes SYNC_STAGES+FILT_CYCLES+1.
//  Not defined: no filter. s is the last synchroniser stage, and no counters are instantiated.
// STRUCTURE
//  Package gpio_int_pkg:
//   state enum {IDLE, PRESENT}
//   GPIO_WIDTH=16, GPIO_IDX_W=$clog2(GPIO_WIDTH)
//   function rr_pick(pending, ptr) -> idx
//  Sub-module gpio_edge_sync: one per bit, generate loop.
//   Contains synchroniser, optional filter and edge detector; outputs hit.
//  Top holds the pending register, round-robin pointer and FSM.
// TESTING
//  1. Mask=0x0001, Edge=0, PortIn[0] 0->1.
//     -> Pending=0x0001 after 3 Clk, IntValid=1, IntVec=0 next Clk.
//     IntAck -> Pending=0, IntValid=0.
//  2. Edge=0x0004, Mask=0x0004, PortIn[2] 1->0 -> IntVec=2.
//     PortIn[2] 0->1 -> no event.
//  3. Mask=0xFFFF, lines 3, 7 and 12 pending together, ptr=0.
//     -> grants 3, 7, 12 in order, with a 1-Clk IntValid gap between each.
//     Re-pend 3 during grant 7 -> 3 is served after 12.
//  4. IntVec=5 presented, IntClr=0x0020 with no ack.
//     -> IntValid drops next Clk and ptr is unchanged.
//     Same again with Mask[5] dropped -> same withdrawal.
//  5. Hit on bit 9 in the same Clk as IntAck for vector 9 -> Pending[9] stays 1, re-presented.
//  6. ResetN low while in PRESENT -> IntValid=0 and Pending=0 immediately.
//     With `GPIO_INT_FILTER_EN: a 2-Clk glitch gives no event; a 4-Clk pulse gives an event.

Source files
------------

// File: rtl/gpio_int_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// gpio_int_pkg
// Shared definitions for the GPIO interrupt sequencer:
//   state_e     - arbiter FSM states (IDLE, PRESENT)
//   GPIO_WIDTH  - number of GPIO lines handled by the sequencer
//   GPIO_IDX_W  - width of a line index
//   rr_pick     - round-robin selection of the next pending line
// Optional feature macro used by this slice: GPIO_INT_FILTER_EN
// -----------------------------------------------------------------------------
package gpio_int_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_e;

   localparam int GPIO_WIDTH = 16;
   localparam int GPIO_IDX_W = $clog2(GPIO_WIDTH);

   // Returns the first set bit of 'pending' at or above 'ptr', wrapping from
   // the top line back to line 0. The index addition wraps naturally because
   // GPIO_WIDTH is a power of two. Callers only use the result when at least
   // one bit is set.
   function automatic logic [GPIO_IDX_W-1:0] rr_pick(
      input logic [GPIO_WIDTH-1:0] pending,
      input logic [GPIO_IDX_W-1:0] ptr
   );
      logic [GPIO_IDX_W-1:0] idx;
      logic [GPIO_IDX_W-1:0] cand;
      logic                  found;
      idx   = ptr;
      found = 1'b0;
      for (int i = 0; i < GPIO_WIDTH; i++) begin
         cand = ptr + GPIO_IDX_W'(i);
         if (!found && pending[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/gpio_int_arbiter_if.sv
// -----------------------------------------------------------------------------
// gpio_int_arbiter_if
// Bundles the register-block and CPU-side signals of the GPIO interrupt
// sequencer.
//   PortIn    raw pin levels
//   IntMask   1 = line enabled
//   IntEdge   0 = rising, 1 = falling
//   IntClr    one-cycle write-one-to-clear of pending bits
//   IntAck    CPU accepts the presented vector
//   Pending   latched pending events
//   IntStatus registered OR of Pending
//   IntValid  IntVec is valid
//   IntVec    index of the presented line
//   dbg_state arbiter FSM state (0 = IDLE, 1 = PRESENT)
//   dbg_ptr   round-robin pointer
// Modports: slave = sequencer side, master = register block / CPU side.
// Optional feature macro affecting the sequencer: GPIO_INT_FILTER_EN
// -----------------------------------------------------------------------------
interface gpio_int_arbiter_if
   import gpio_int_pkg::*;
#(
   parameter int WIDTH = GPIO_WIDTH
) ();

   localparam int IDX_W = $clog2(WIDTH);

   logic [WIDTH-1:0] PortIn;
   logic [WIDTH-1:0] IntMask;
   logic [WIDTH-1:0] IntEdge;
   logic [WIDTH-1:0] IntClr;
   logic             IntAck;
   logic [WIDTH-1:0] Pending;
   logic             IntStatus;
   logic             IntValid;
   logic [IDX_W-1:0] IntVec;
   logic [0:0]       dbg_state;
   logic [IDX_W-1:0] dbg_ptr;

   // Handshake: a vector transfers on a clock edge where IntValid and IntAck
   // are both high. While IntValid is high, IntVec is held stable; IntValid
   // can also fall without an ack when the presented line is cleared or masked
   // (withdrawal). IntAck while IntValid is low has no effect. After each
   // transfer or withdrawal IntValid stays low for at least one cycle.

   modport slave (
      input  PortIn, IntMask, IntEdge, IntClr, IntAck,
      output Pending, IntStatus, IntValid, IntVec, dbg_state, dbg_ptr
   );

   modport master (
      output PortIn, IntMask, IntEdge, IntClr, IntAck,
      input  Pending, IntStatus, IntValid, IntVec, dbg_state, dbg_ptr
   );

endinterface

// File: rtl/gpio_int_arbiter_edge_sync.sv
// -----------------------------------------------------------------------------
// gpio_edge_sync
// Per-line front end: SYNC_STAGES-deep synchroniser, optional glitch filter,
// and a rising/falling edge detector.
//   clk      clock
//   rst_n    asynchronous active-low reset
//   pin      raw pin level
//   edge_sel 0 = rising, 1 = falling
//   hit      one-cycle event on the selected edge
// With GPIO_INT_FILTER_EN defined, the detected level only changes after the
// synchronised input has disagreed with it for FILT_CYCLES consecutive cycles.
// -----------------------------------------------------------------------------
module gpio_edge_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   input  logic edge_sel,
   output logic hit
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("gpio_edge_sync: SYNC_STAGES must be at least 2");
   end
   if (FILT_CYCLES < 1) begin : g_bad_filt
      $error("gpio_edge_sync: FILT_CYCLES must be at least 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   p_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      end
   end

`ifdef GPIO_INT_FILTER_EN
   localparam int CNT_W = $clog2(FILT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             filt_q;

   // The counter tracks how long the synchronised input has disagreed with
   // the filtered level; any cycle of agreement (a bounce) restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILT_CYCLES - 1)) begin
         cnt_q  <= '0;
         filt_q <= sync_q[SYNC_STAGES-1];
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign s = filt_q;
`else
   assign s = sync_q[SYNC_STAGES-1];
`endif

   // p resets to 0, so a pin already high at reset release yields a rising hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= 1'b0;
      end else begin
         p_q <= s;
      end
   end

   assign hit = edge_sel ? (p_q & ~s) : (s & ~p_q);

endmodule

// File: rtl/gpio_int_arbiter.sv
// -----------------------------------------------------------------------------
// gpio_int_arbiter
// Interrupt sequencer for the GPIO port: edge events per line are latched into
// pending bits and presented one vector at a time to the CPU, round-robin.
//   Clk    single clock, all state on its rising edge
//   ResetN asynchronous active-low reset
//   bus    gpio_int_arbiter_if.slave (pins, mask/edge/clear, CPU handshake,
//          pending/status outputs, FSM state and pointer debug outputs)
// Optional feature: define GPIO_INT_FILTER_EN to insert a per-line glitch
// filter (FILT_CYCLES stable cycles) after the synchroniser.
// -----------------------------------------------------------------------------
module gpio_int_arbiter
   import gpio_int_pkg::*;
#(
   parameter int WIDTH       = GPIO_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 4
) (
   input logic              Clk,
   input logic              ResetN,
   gpio_int_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(WIDTH);

   localparam logic [0:0] ST_IDLE    = IDLE;
   localparam logic [0:0] ST_PRESENT = PRESENT;

   logic [WIDTH-1:0] hit;
   logic [WIDTH-1:0] pending_q;
   logic [WIDTH-1:0] pending_d;
   logic [WIDTH-1:0] ack_clr;
   logic             status_q;
   logic             valid_q;
   logic [IDX_W-1:0] vec_q;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] pick;
   logic [IDX_W-1:0] ptr_next;
   logic [0:0]       state_q;
   logic             handshake;

   for (genvar g = 0; g < WIDTH; g++) begin : g_line
      gpio_edge_sync #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_CYCLES (FILT_CYCLES)
      ) u_edge_sync (
         .clk      (Clk),
         .rst_n    (ResetN),
         .pin      (bus.PortIn[g]),
         .edge_sel (bus.IntEdge[g]),
         .hit      (hit[g])
      );
   end

   assign handshake = (state_q == ST_PRESENT) && bus.IntAck;
   assign ack_clr   = handshake ? (WIDTH'(1) << vec_q) : '0;

   // A hit in the same cycle as its clear or ack keeps the bit set; the mask
   // is applied last so a disabled line never holds a pending bit.
   assign pending_d = ((pending_q & ~bus.IntClr & ~ack_clr) | hit) & bus.IntMask;

   assign pick     = rr_pick(pending_q, ptr_q);
   assign ptr_next = (vec_q == IDX_W'(WIDTH - 1)) ? '0 : vec_q + 1'b1;

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         pending_q <= '0;
         status_q  <= 1'b0;
      end else begin
         pending_q <= pending_d;
         status_q  <= |pending_q;
      end
   end

   // IDLE always lasts at least one cycle, which gives IntValid its gap
   // between consecutive vectors.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         vec_q   <= '0;
         ptr_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|pending_q) begin
                  vec_q   <= pick;
                  valid_q <= 1'b1;
                  state_q <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (bus.IntAck) begin
                  ptr_q   <= ptr_next;
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (!pending_q[vec_q]) begin
                  // Line cleared or masked while presented: withdraw and keep
                  // the pointer so fairness is unaffected.
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.Pending   = pending_q;
   assign bus.IntStatus = status_q;
   assign bus.IntValid  = valid_q;
   assign bus.IntVec    = vec_q;
   assign bus.dbg_state = state_q;
   assign bus.dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_gpio_int_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpio_int_arbiter
// Directed bench for gpio_int_arbiter: a table of single-transition vectors
// followed by hand-written sequences for round-robin order, withdrawal,
// hit-versus-ack, mid-handshake reset and (with GPIO_INT_FILTER_EN) the
// glitch filter.
// -----------------------------------------------------------------------------
module tb_gpio_int_arbiter;
   import gpio_int_pkg::*;

`ifdef GPIO_INT_FILTER_EN
   localparam int FILT = 4;
`else
   localparam int FILT = 0;
`endif
   localparam int LAT    = 2 + FILT + 1;
   localparam int SETTLE = LAT + 3;

   typedef struct {
      logic [15:0] mask;
      logic [15:0] edge_cfg;
      logic [15:0] pin_from;
      logic [15:0] pin_to;
      logic [15:0] exp_pend;
      logic [3:0]  exp_vec;
      bit          ack;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          checks = 0;
   int          errors = 0;
   logic [3:0]  exp_q[$];
   logic [3:0]  ptr_model;
   logic [3:0]  last_vec;
   vec_t        tbl[8];

   gpio_int_arbiter_if #(.WIDTH(16)) bus ();

   gpio_int_arbiter dut (
      .Clk    (clk),
      .ResetN (rst_n),
      .bus    (bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers / drivers ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.PortIn  = '0;
      bus.IntMask = '0;
      bus.IntEdge = '0;
      bus.IntClr  = '0;
      bus.IntAck  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      ptr_model = '0;
   endtask

   // Scoreboard: wait (bounded) for a presented vector and compare it with
   // the head of the expected queue.
   task automatic wait_grant(input string name);
      int n;
      logic [3:0] exp_v;
      n = 0;
      exp_v = exp_q.pop_front();
      last_vec = exp_v;
      while (!bus.IntValid && n < 100) begin
         tick();
         n++;
      end
      if (!bus.IntValid) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout waiting for IntValid, expected vector %0d", name, exp_v);
      end else begin
         check(name, 32'(bus.IntVec), 32'(exp_v));
      end
   endtask

   task automatic ack_grant(input string name);
      bus.IntAck = 1'b1;
      tick();
      bus.IntAck = 1'b0;
      ptr_model = last_vec + 4'd1;
      check({name, " gap"}, 32'(bus.IntValid), 32'd0);
      check({name, " ptr"}, 32'(bus.dbg_ptr), 32'(ptr_model));
   endtask

   // ---------------- test ----------------
   initial begin
      drive_idle();
      rst_n = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      check("reset Pending",   32'(bus.Pending),   32'd0);
      check("reset IntStatus", 32'(bus.IntStatus), 32'd0);
      check("reset IntValid",  32'(bus.IntValid),  32'd0);
      check("reset IntVec",    32'(bus.IntVec),    32'd0);
      check("reset ptr",       32'(bus.dbg_ptr),   32'd0);
      check("reset state",     32'(bus.dbg_state), 32'd0);
      tick(2);
      rst_n = 1'b1;
      ptr_model = '0;
      tick();

      // mask, edge, from, to, expected pending, expected vector, ack
      tbl[0] = '{16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 4'd0,  1'b1};
      tbl[1] = '{16'h0004, 16'h0004, 16'h0004, 16'h0000, 16'h0004, 4'd2,  1'b1};
      tbl[2] = '{16'h0004, 16'h0004, 16'h0000, 16'h0004, 16'h0000, 4'd0,  1'b0};
      tbl[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 4'd0,  1'b0};
      tbl[4] = '{16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 4'd15, 1'b1};
      tbl[5] = '{16'h00F0, 16'h0030, 16'h0030, 16'h00C0, 16'h00F0, 4'd4,  1'b1};
      tbl[6] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  1'b0};
      tbl[7] = '{16'h0A00, 16'h0800, 16'h0800, 16'h0200, 16'h0A00, 4'd9,  1'b1};

      for (int i = 0; i < 8; i++) begin
         bus.IntMask = '0;
         bus.IntEdge = tbl[i].edge_cfg;
         bus.PortIn  = tbl[i].pin_from;
         tick(SETTLE);
         bus.IntMask = tbl[i].mask;
         tick();
         bus.PortIn = tbl[i].pin_to;
         tick(LAT - 1);
         check($sformatf("v%0d Pending early", i), 32'(bus.Pending), 32'd0);
         tick();
         check($sformatf("v%0d Pending", i), 32'(bus.Pending), 32'(tbl[i].exp_pend));
         tick();
         check($sformatf("v%0d IntValid", i), 32'(bus.IntValid), 32'(tbl[i].exp_pend != 0));
         check($sformatf("v%0d IntStatus", i), 32'(bus.IntStatus), 32'(tbl[i].exp_pend != 0));
         if (tbl[i].exp_pend != 0) begin
            check($sformatf("v%0d IntVec", i), 32'(bus.IntVec), 32'(tbl[i].exp_vec));
         end
         if (tbl[i].ack) begin
            bus.IntAck = 1'b1;
            tick();
            bus.IntAck = 1'b0;
            ptr_model = tbl[i].exp_vec + 4'd1;
            check($sformatf("v%0d Pending after ack", i), 32'(bus.Pending),
                  32'(tbl[i].exp_pend & ~(16'd1 << tbl[i].exp_vec)));
            check($sformatf("v%0d IntValid after ack", i), 32'(bus.IntValid), 32'd0);
            check($sformatf("v%0d ptr", i), 32'(bus.dbg_ptr), 32'(ptr_model));
         end
      end

      // ---- round robin: 3, 7, 12 together; 3 re-pends during grant 7 ----
      drive_idle();
      do_reset();
      bus.IntMask = 16'hFFFF;
      tick();
      bus.PortIn = 16'h1088;
      tick(LAT);
      check("rr Pending", 32'(bus.Pending), 32'h1088);
      exp_q.push_back(4'd3);
      exp_q.push_back(4'd7);
      exp_q.push_back(4'd12);
      exp_q.push_back(4'd3);
      wait_grant("rr grant 3");
      ack_grant("rr ack 3");
      bus.PortIn = bus.PortIn & ~16'h0008;
      tick(SETTLE);
      wait_grant("rr grant 7");
      bus.PortIn = bus.PortIn | 16'h0008;
      tick(LAT + 1);
      check("rr re-pend 3", 32'(bus.Pending), 32'h1088);
      check("rr 7 held valid", 32'(bus.IntValid), 32'd1);
      check("rr 7 held vec", 32'(bus.IntVec), 32'd7);
      ack_grant("rr ack 7");
      wait_grant("rr grant 12");
      ack_grant("rr ack 12");
      wait_grant("rr grant 3 again");
      ack_grant("rr ack 3 again");
      check("rr Pending empty", 32'(bus.Pending), 32'd0);

      // ---- withdrawal via IntClr, then via mask ----
      drive_idle();
      do_reset();
      bus.IntMask = 16'hFFFF;
      tick();
      bus.PortIn = 16'h0020;
      exp_q.push_back(4'd5);
      wait_grant("wd clr grant");
      bus.IntClr = 16'h0020;
      tick();
      bus.IntClr = '0;
      check("wd clr Pending", 32'(bus.Pending), 32'd0);
      tick();
      check("wd clr IntValid", 32'(bus.IntValid), 32'd0);
      check("wd clr ptr", 32'(bus.dbg_ptr), 32'd0);
      bus.PortIn = '0;
      tick(SETTLE);
      bus.PortIn = 16'h0020;
      exp_q.push_back(4'd5);
      wait_grant("wd mask grant");
      bus.IntMask = 16'hFFDF;
      tick();
      check("wd mask Pending", 32'(bus.Pending), 32'd0);
      tick();
      check("wd mask IntValid", 32'(bus.IntValid), 32'd0);
      check("wd mask ptr", 32'(bus.dbg_ptr), 32'd0);
      bus.IntMask = 16'hFFFF;

      // ---- new hit on line 9 in the same cycle as its ack ----
      drive_idle();
      do_reset();
      bus.IntMask = 16'hFFFF;
      tick();
      bus.PortIn = 16'h0200;
      exp_q.push_back(4'd9);
      wait_grant("hit-ack grant");
      bus.PortIn = '0;
      tick(SETTLE);
      bus.PortIn = 16'h0200;
      tick(LAT - 1);
      bus.IntAck = 1'b1;
      tick();
      bus.IntAck = 1'b0;
      check("hit-ack Pending", 32'(bus.Pending), 32'h0200);
      check("hit-ack IntValid gap", 32'(bus.IntValid), 32'd0);
      check("hit-ack ptr", 32'(bus.dbg_ptr), 32'd10);
      tick();
      check("hit-ack re-present valid", 32'(bus.IntValid), 32'd1);
      check("hit-ack re-present vec", 32'(bus.IntVec), 32'd9);

      // ---- asynchronous reset while presenting ----
      #2;
      rst_n = 1'b0;
      #1;
      check("mid reset IntValid", 32'(bus.IntValid), 32'd0);
      check("mid reset Pending", 32'(bus.Pending), 32'd0);
      check("mid reset IntStatus", 32'(bus.IntStatus), 32'd0);
      check("mid reset ptr", 32'(bus.dbg_ptr), 32'd0);
      tick(2);
      rst_n = 1'b1;
      // Pin 9 is still high: the first sample after reset is a rising hit.
      tick(LAT - 1);
      check("post reset Pending early", 32'(bus.Pending), 32'd0);
      tick();
      check("post reset Pending", 32'(bus.Pending), 32'h0200);

`ifdef GPIO_INT_FILTER_EN
      // ---- glitch filter: 2-cycle glitch rejected, 4-cycle pulse kept ----
      drive_idle();
      do_reset();
      bus.IntMask = 16'hFFFF;
      tick(SETTLE);
      bus.PortIn = 16'h0002;
      tick(2);
      bus.PortIn = '0;
      tick(SETTLE);
      check("filt glitch Pending", 32'(bus.Pending), 32'd0);
      bus.PortIn = 16'h0002;
      tick(4);
      bus.PortIn = '0;
      tick(SETTLE);
      check("filt pulse Pending", 32'(bus.Pending), 32'h0002);
`endif

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard drain: %0d expected vectors left over, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
